// File: rtl/sao_stat_pkg.sv
// Shared types and default sizing for the SAO per-CTB statistics accumulator.
// Saturation behaviour is selected by the SAO_STAT_SAT_EN macro.
package sao_stat_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int DIFF_CLIP_BIT_DEF = 4;
    localparam int N_BO_TYPE_DEF     = 5;
    localparam int NUM_CATE_DEF      = 32;
    localparam int SUM_W_DEF         = 18;
    localparam int CNT_W_DEF         = 13;

    localparam int SUM_MAX_DEF = (2 ** (SUM_W_DEF - 1)) - 1;
    localparam int SUM_MIN_DEF = -(2 ** (SUM_W_DEF - 1));
    localparam int CNT_MAX_DEF = (2 ** CNT_W_DEF) - 1;

endpackage

// File: rtl/sao_stat_ctb_accum_if.sv
// Beat input, CTB control and drain output bundle of sao_stat_ctb_accum.
// slave = accumulator side, master = upstream adders / downstream decision stage.
interface sao_stat_ctb_accum_if
    import sao_stat_pkg::*;
#(
    parameter int diff_clip_bit = DIFF_CLIP_BIT_DEF,
    parameter int n_bo_type     = N_BO_TYPE_DEF,
    parameter int SUM_W         = SUM_W_DEF,
    parameter int CNT_W         = CNT_W_DEF
);
    logic                            ctb_start;
    logic                            ctb_end;
    logic                            in_valid;
    logic                            in_ready;
    logic [n_bo_type-1:0]            in_cate;
    logic signed [diff_clip_bit+3:0] in_s81;
    logic [3:0]                      in_cnt;
    logic                            out_valid;
    logic                            out_ready;
    logic [n_bo_type-1:0]            out_cate;
    logic signed [SUM_W-1:0]         out_sum;
    logic [CNT_W-1:0]                out_cnt;
    logic                            out_last;
    logic                            out_sat;

    modport slave (
        input  ctb_start, ctb_end, in_valid, in_cate, in_s81, in_cnt, out_ready,
        output in_ready, out_valid, out_cate, out_sum, out_cnt, out_last, out_sat
    );

    modport master (
        output ctb_start, ctb_end, in_valid, in_cate, in_s81, in_cnt, out_ready,
        input  in_ready, out_valid, out_cate, out_sum, out_cnt, out_last, out_sat
    );
endinterface

// File: rtl/sao_stat_acc_upd.sv
// Combinational (sum,cnt) + (beat sum, beat count) update for one category.
// SAO_STAT_SAT_EN: clamp to the register ranges and flag it; otherwise wrap.
module sao_stat_acc_upd #(
    parameter int diff_clip_bit = 4,
    parameter int SUM_W         = 18,
    parameter int CNT_W         = 13
) (
    input  logic signed [SUM_W-1:0]         sum_i,
    input  logic [CNT_W-1:0]                cnt_i,
    input  logic signed [diff_clip_bit+3:0] s81_i,
    input  logic [3:0]                      cnt8_i,
    output logic signed [SUM_W-1:0]         sum_o,
    output logic [CNT_W-1:0]                cnt_o,
    output logic                            sat_o
);

`ifdef SAO_STAT_SAT_EN
    localparam logic signed [SUM_W-1:0] SUM_MAX = {1'b0, {(SUM_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};

    logic signed [SUM_W:0] wide_sum;
    logic [CNT_W:0]        wide_cnt;
    logic                  sum_ovf;
    logic                  cnt_ovf;

    always_comb begin
        wide_sum = (SUM_W+1)'(sum_i) + (SUM_W+1)'(s81_i);
        wide_cnt = {1'b0, cnt_i} + (CNT_W+1)'(cnt8_i);
        // One guard bit: overflow iff the two top bits disagree.
        sum_ovf  = wide_sum[SUM_W] ^ wide_sum[SUM_W-1];
        cnt_ovf  = wide_cnt[CNT_W];

        if (sum_ovf) begin
            sum_o = wide_sum[SUM_W] ? SUM_MIN : SUM_MAX;
        end else begin
            sum_o = wide_sum[SUM_W-1:0];
        end
        cnt_o = cnt_ovf ? '1 : wide_cnt[CNT_W-1:0];
        sat_o = sum_ovf | cnt_ovf;
    end
`else
    always_comb begin
        sum_o = sum_i + SUM_W'(s81_i);
        cnt_o = cnt_i + CNT_W'(cnt8_i);
        sat_o = 1'b0;
    end
`endif

endmodule

// File: rtl/sao_stat_ctb_accum.sv
// Per-CTB SAO category sum/count accumulator with a valid/ready drain of all categories.
// Optional saturation via SAO_STAT_SAT_EN (see sao_stat_acc_upd).
module sao_stat_ctb_accum
    import sao_stat_pkg::*;
#(
    parameter int diff_clip_bit = DIFF_CLIP_BIT_DEF,
    parameter int n_bo_type     = N_BO_TYPE_DEF,
    parameter int NUM_CATE      = NUM_CATE_DEF,
    parameter int SUM_W         = SUM_W_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input logic                  clk,
    input logic                  rst,
    sao_stat_ctb_accum_if.slave  bus
);

    localparam logic [n_bo_type-1:0] LAST_IDX = n_bo_type'(NUM_CATE - 1);

    state_e state_q, state_d;

    logic signed [SUM_W-1:0] sum_q [NUM_CATE];
    logic [CNT_W-1:0]        cnt_q [NUM_CATE];

    logic                    out_valid_q, out_valid_d;
    logic [n_bo_type-1:0]    out_cate_q,  out_cate_d;
    logic signed [SUM_W-1:0] out_sum_q,   out_sum_d;
    logic [CNT_W-1:0]        out_cnt_q,   out_cnt_d;
    logic                    out_last_q,  out_last_d;
    logic                    sat_q,       sat_d;

    logic                    beat_acc;
    logic signed [SUM_W-1:0] upd_sum;
    logic [CNT_W-1:0]        upd_cnt;
    logic                    upd_sat;
    logic [n_bo_type-1:0]    nxt_idx;

    assign beat_acc = (state_q == ACCUM) && bus.in_valid;
    assign nxt_idx  = out_cate_q + n_bo_type'(1);

    sao_stat_acc_upd #(
        .diff_clip_bit (diff_clip_bit),
        .SUM_W         (SUM_W),
        .CNT_W         (CNT_W)
    ) u_upd (
        .sum_i  (sum_q[bus.in_cate]),
        .cnt_i  (cnt_q[bus.in_cate]),
        .s81_i  (bus.in_s81),
        .cnt8_i (bus.in_cnt),
        .sum_o  (upd_sum),
        .cnt_o  (upd_cnt),
        .sat_o  (upd_sat)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_cate_d  = out_cate_q;
        out_sum_d   = out_sum_q;
        out_cnt_d   = out_cnt_q;
        out_last_d  = out_last_q;
        sat_d       = sat_q;

        case (state_q)
            IDLE: begin
                if (bus.ctb_start) begin
                    state_d = ACCUM;
                    sat_d   = 1'b0;
                end
            end
            ACCUM: begin
                if (beat_acc && upd_sat) begin
                    sat_d = 1'b1;
                end
                if (bus.ctb_end) begin
                    state_d     = DRAIN;
                    out_valid_d = 1'b1;
                    out_cate_d  = '0;
                    out_last_d  = (LAST_IDX == '0);
                    // A closing beat aimed at category 0 must already appear in the first drain word.
                    if (beat_acc && (bus.in_cate == '0)) begin
                        out_sum_d = upd_sum;
                        out_cnt_d = upd_cnt;
                    end else begin
                        out_sum_d = sum_q[0];
                        out_cnt_d = cnt_q[0];
                    end
                end
            end
            DRAIN: begin
                if (out_valid_q && bus.out_ready) begin
                    if (out_last_q) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        out_cate_d = nxt_idx;
                        out_sum_d  = sum_q[nxt_idx];
                        out_cnt_d  = cnt_q[nxt_idx];
                        out_last_d = (nxt_idx == LAST_IDX);
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_cate_q  <= '0;
            out_sum_q   <= '0;
            out_cnt_q   <= '0;
            out_last_q  <= 1'b0;
            sat_q       <= 1'b0;
            for (int unsigned i = 0; i < NUM_CATE; i++) begin
                sum_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_cate_q  <= out_cate_d;
            out_sum_q   <= out_sum_d;
            out_cnt_q   <= out_cnt_d;
            out_last_q  <= out_last_d;
            sat_q       <= sat_d;
            if ((state_q == IDLE) && bus.ctb_start) begin
                for (int unsigned i = 0; i < NUM_CATE; i++) begin
                    sum_q[i] <= '0;
                    cnt_q[i] <= '0;
                end
            end else if (beat_acc) begin
                sum_q[bus.in_cate] <= upd_sum;
                cnt_q[bus.in_cate] <= upd_cnt;
            end
        end
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = out_valid_q;
    assign bus.out_cate  = out_cate_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cnt   = out_cnt_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_sat   = sat_q;

endmodule
